// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl: single-clock VGA timing generator with pixel strobe and frame-paced game_step.
// Decode outputs are registered from the next counter values so they line up with h_cnt/v_cnt.
module vga_timing_ctrl #(
    parameter int DIV      = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       clock100,
    input  logic       resetn,
    input  logic       in_EN,
    input  logic [3:0] speed,
    output logic       pix_en,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic       frame_start,
    output logic       game_step
);
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] P_LAST   = PW'(DIV - 1);
    localparam logic [9:0]    H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0]    V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0]    H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0]    V_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0]    HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0]    HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]    VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]    VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [PW-1:0] presc;
    logic [9:0]    h_cnt, v_cnt, h_nxt, v_nxt;
    logic [3:0]    frame_cnt;
    logic          h_wrap, v_wrap, vis_nxt;

    assign h_wrap      = h_cnt == H_LAST;
    assign v_wrap      = v_cnt == V_LAST;
    assign pix_en      = in_EN && presc == P_LAST;
    assign frame_start = pix_en && h_wrap && v_wrap;
    // period - 1 = 15 - speed, which is the bitwise complement of a 4-bit speed
    assign game_step   = frame_start && frame_cnt >= ~speed;

    always_comb begin
        h_nxt   = pix_en ? (h_wrap ? 10'd0 : h_cnt + 10'd1) : h_cnt;
        v_nxt   = (pix_en && h_wrap) ? (v_wrap ? 10'd0 : v_cnt + 10'd1) : v_cnt;
        vis_nxt = h_nxt < H_VIS && v_nxt < V_VIS;
    end

    always_ff @(posedge clock100 or negedge resetn) begin
        if (!resetn) begin
            presc     <= '0;
            h_cnt     <= '0;
            v_cnt     <= '0;
            frame_cnt <= '0;
            hsync     <= 1'b1;
            vsync     <= 1'b1;
            video_on  <= 1'b0;
            pix_x     <= '0;
            pix_y     <= '0;
        end else if (in_EN) begin
            presc     <= (presc == P_LAST) ? '0 : presc + PW'(1);
            h_cnt     <= h_nxt;
            v_cnt     <= v_nxt;
            frame_cnt <= frame_start ? (game_step ? 4'd0 : frame_cnt + 4'd1) : frame_cnt;
            hsync     <= !(h_nxt >= HS_START && h_nxt < HS_END);
            vsync     <= !(v_nxt >= VS_START && v_nxt < VS_END);
            video_on  <= vis_nxt;
            pix_x     <= vis_nxt ? h_nxt : 10'd0;
            pix_y     <= vis_nxt ? v_nxt : 10'd0;
        end
    end
endmodule

// File: tb/tb_vga_timing_ctrl.sv
// tb_vga_timing_ctrl: directed checks of a full-size instance (line timing) and a shrunken one (frame/game_step).
// Shrunken geometry: 15 pixels x 10 lines, DIV 4 -> 60 clocks per line, 600 per frame.
module tb_vga_timing_ctrl;
    logic       clk = 1'b0, resetn = 1'b0, in_en = 1'b1;
    logic [3:0] speed = 4'd15;
    logic       f_pix_en, f_hsync, f_vsync, f_video_on, f_frame_start, f_game_step;
    logic       s_pix_en, s_hsync, s_vsync, s_video_on, s_frame_start, s_game_step;
    logic [9:0] f_pix_x, f_pix_y, s_pix_x, s_pix_y;
    logic [25:0] f_vec, s_vec;
    localparam logic [25:0] RST_VEC = {6'b011000, 20'd0};
    int errors = 0, checks = 0;

    always #5 clk = ~clk;

    vga_timing_ctrl dut_full (
        .clock100(clk), .resetn(resetn), .in_EN(in_en), .speed(speed),
        .pix_en(f_pix_en), .hsync(f_hsync), .vsync(f_vsync), .video_on(f_video_on),
        .pix_x(f_pix_x), .pix_y(f_pix_y), .frame_start(f_frame_start), .game_step(f_game_step)
    );

    vga_timing_ctrl #(
        .DIV(4), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) dut_small (
        .clock100(clk), .resetn(resetn), .in_EN(in_en), .speed(speed),
        .pix_en(s_pix_en), .hsync(s_hsync), .vsync(s_vsync), .video_on(s_video_on),
        .pix_x(s_pix_x), .pix_y(s_pix_y), .frame_start(s_frame_start), .game_step(s_game_step)
    );

    assign f_vec = {f_pix_en, f_hsync, f_vsync, f_video_on, f_frame_start, f_game_step, f_pix_x, f_pix_y};
    assign s_vec = {s_pix_en, s_hsync, s_vsync, s_video_on, s_frame_start, s_game_step, s_pix_x, s_pix_y};

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int fs_q[$], gs_q[$];
        int gs_exp[5] = '{599, 1199, 3599, 5399, 5999};
        logic [11:0] mask;
        logic [2:0]  rmask;
        int s_vid = 0, s_vs = 0, s_hs = 0, s_vs_first = -1;
        int f_vid = 0, f_hs = 0, f_vs = 0, f_fs = 0, f_hs_first = -1;
        int bad_coinc = 0, pulses = 0, xbad = 0, n = 0;
        mask = '0;
        rmask = '0;

        repeat (5) @(posedge clk);
        @(negedge clk);
        check("reset_full", int'(f_vec), int'(RST_VEC));
        check("reset_small", int'(s_vec), int'(RST_VEC));
        resetn = 1'b1;

        for (int e = 1; e <= 6400; e++) begin
            tick();
            if (e <= 12) mask[e-1] = s_pix_en;
            if (s_frame_start) fs_q.push_back(e);
            if (s_game_step) gs_q.push_back(e);
            if (s_frame_start && !s_pix_en) bad_coinc++;
            if (e >= 600 && e < 1200) begin
                s_vid += int'(s_video_on);
                s_vs  += int'(!s_vsync);
                s_hs  += int'(!s_hsync);
                if (!s_vsync && s_vs_first < 0) s_vs_first = e;
            end
            if (e >= 3200 && e < 6400) begin
                f_vid += int'(f_video_on);
                f_hs  += int'(!f_hsync);
                f_vs  += int'(!f_vsync);
                f_fs  += int'(f_frame_start);
                if (!f_hsync && f_hs_first < 0) f_hs_first = e;
            end
            if (e == 680) check("small_xy", int'({s_pix_y, s_pix_x}), (1 << 10) | 5);
            if (e == 650) check("small_blank_xy", int'({s_video_on, s_hsync, s_pix_y, s_pix_x}), 0);
            if (e == 4402) check("full_pix_x", int'(f_pix_x), 300);
            if (e == 1200) speed = 4'd12;
            if (e == 4800) speed = 4'd15;
        end

        check("pix_en_phase", int'(mask), 12'b0100_0100_0100);
        check("small_video_cnt", s_vid, 192);
        check("small_vsync_cnt", s_vs, 120);
        check("small_vsync_first", s_vs_first, 1020);
        check("small_hsync_cnt", s_hs, 120);
        check("full_video_cnt", f_vid, 2560);
        check("full_hsync_cnt", f_hs, 384);
        check("full_hsync_first", f_hs_first, 5824);
        check("full_vsync_cnt", f_vs, 0);
        check("full_frame_cnt", f_fs, 0);
        check("fs_coincident", bad_coinc, 0);
        check("fs_count", fs_q.size(), 10);
        foreach (fs_q[i]) if (i < 10) check($sformatf("fs_at_%0d", i), fs_q[i], 599 + 600 * i);
        check("gs_count", gs_q.size(), 5);
        foreach (gs_q[i]) if (i < 5) check($sformatf("gs_at_%0d", i), gs_q[i], gs_exp[i]);

        repeat (1201) tick();
        check("hold_pre_x", int'(f_pix_x), 300);
        in_en = 1'b0;
        repeat (1000) begin
            tick();
            pulses += int'(f_pix_en | f_frame_start | f_game_step | s_pix_en | s_frame_start | s_game_step);
            if (f_pix_x != 10'd300) xbad++;
        end
        check("hold_pulses", pulses, 0);
        check("hold_pix_x", xbad, 0);
        in_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            rmask[i] = f_pix_en;
            if (i == 1) check("resume_x_before", int'(f_pix_x), 300);
        end
        check("resume_pix_en", int'(rmask), 3'b010);
        check("resume_x_after", int'(f_pix_x), 301);

        repeat (50) tick();
        @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        check("async_rst_full", int'(f_vec), int'(RST_VEC));
        check("async_rst_small", int'(s_vec), int'(RST_VEC));
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        while (!s_frame_start && n < 2000) begin
            tick();
            n++;
        end
        check("rst_first_frame", n, 599);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
